// File: rtl/buzzer_sequencer_if.sv
// Request/status and buzzer-stage signals of buzzer_sequencer.
// timeout_err exists only when BUZZER_SEQ_TIMEOUT_EN is defined.
interface buzzer_sequencer_if;
    // start is a one-cycle request with no ready: it is taken only while busy=0
    // (IDLE/DONE) and stop=0; otherwise it is dropped, never queued.
    logic       start;
    logic       stop;
    logic [3:0] repeat_cnt;
    logic       buzz_done;
    logic       buzz_restart;
    logic       busy;
    logic       finished;
    logic [3:0] play_index;
    logic [2:0] dbg_state;
`ifdef BUZZER_SEQ_TIMEOUT_EN
    logic       timeout_err;

    modport slave (
        input  start, stop, repeat_cnt, buzz_done,
        output buzz_restart, busy, finished, play_index, dbg_state, timeout_err
    );
    modport master (
        output start, stop, repeat_cnt, buzz_done,
        input  buzz_restart, busy, finished, play_index, dbg_state, timeout_err
    );
`else
    modport slave (
        input  start, stop, repeat_cnt, buzz_done,
        output buzz_restart, busy, finished, play_index, dbg_state
    );
    modport master (
        output start, stop, repeat_cnt, buzz_done,
        input  buzz_restart, busy, finished, play_index, dbg_state
    );
`endif
endinterface

// File: rtl/buzzer_sequencer.sv
// Plays the downstream buzzer tune N times (or forever) with arm and gap phases; stop aborts.
// Optional PLAY watchdog with sticky timeout_err: define BUZZER_SEQ_TIMEOUT_EN.
module buzzer_sequencer #(
    parameter int ARM_CYCLES     = 4,
    parameter int GAP_CYCLES     = 1000,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic               clk,
    input logic               reset,
    buzzer_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_PLAY = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int               ARM_N    = (ARM_CYCLES < 2) ? 2 : ARM_CYCLES;
    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_N - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       plays_left, plays_left_n;
    logic [3:0]       play_index, play_index_n;
    logic             restart, restart_n;
    logic             busy, busy_n;
    logic             finished, finished_n;
    logic             first_play, first_play_n;

`ifdef BUZZER_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic             terr, terr_n;
`else
    // Keeps the watchdog limit referenced when the watchdog is compiled out.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        plays_left_n = plays_left;
        play_index_n = play_index;
        restart_n    = 1'b1;
        finished_n   = 1'b0;
        first_play_n = 1'b0;
`ifdef BUZZER_SEQ_TIMEOUT_EN
        terr_n       = terr;
`endif
        if (bus.stop) begin
            state_n      = S_IDLE;
            cnt_n        = '0;
            play_index_n = 4'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_n      = S_ARM;
                        plays_left_n = bus.repeat_cnt;
                        play_index_n = 4'd1;
                        cnt_n        = '0;
`ifdef BUZZER_SEQ_TIMEOUT_EN
                        terr_n       = 1'b0;
`endif
                    end
                end
                S_ARM: begin
                    if (cnt == ARM_LAST) begin
                        state_n      = S_PLAY;
                        cnt_n        = '0;
                        restart_n    = 1'b0;
                        first_play_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_PLAY: begin
                    restart_n = 1'b0;
                    // The done flag is still left over from the previous play on the first PLAY cycle.
                    if (!first_play && bus.buzz_done) begin
                        restart_n = 1'b1;
                        cnt_n     = '0;
                        if (plays_left == 4'd1) begin
                            state_n    = S_DONE;
                            finished_n = 1'b1;
                        end else begin
                            if (plays_left != 4'd0) plays_left_n = plays_left - 4'd1;
                            play_index_n = play_index + 4'd1;
                            state_n      = (GAP_CYCLES > 0) ? S_GAP : S_ARM;
                        end
                    end
`ifdef BUZZER_SEQ_TIMEOUT_EN
                    else if (cnt == TO_LAST) begin
                        state_n   = S_IDLE;
                        restart_n = 1'b1;
                        cnt_n     = '0;
                        terr_n    = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state_n = S_ARM;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
        busy_n = (state_n == S_ARM) || (state_n == S_PLAY) || (state_n == S_GAP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            plays_left <= 4'd0;
            play_index <= 4'd0;
            restart    <= 1'b1;
            busy       <= 1'b0;
            finished   <= 1'b0;
            first_play <= 1'b0;
`ifdef BUZZER_SEQ_TIMEOUT_EN
            terr       <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            plays_left <= plays_left_n;
            play_index <= play_index_n;
            restart    <= restart_n;
            busy       <= busy_n;
            finished   <= finished_n;
            first_play <= first_play_n;
`ifdef BUZZER_SEQ_TIMEOUT_EN
            terr       <= terr_n;
`endif
        end
    end

    assign bus.buzz_restart = restart;
    assign bus.busy         = busy;
    assign bus.finished     = finished;
    assign bus.play_index   = play_index;
    assign bus.dbg_state    = state;
`ifdef BUZZER_SEQ_TIMEOUT_EN
    assign bus.timeout_err  = terr;
`endif

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Bench for buzzer_sequencer: control-vector table, then play sequences checked against
// an expected per-cycle trace built from play lengths. Timeout checks need BUZZER_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_buzzer_sequencer;
    localparam int ARM = 4;
    localparam int GAP = 10;
    localparam int TO  = 200;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    buzzer_sequencer_if bus ();

    buzzer_sequencer #(
        .ARM_CYCLES(ARM), .GAP_CYCLES(GAP), .CNT_W(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct packed {
        logic       start;
        logic       stop;
        logic [3:0] rep;
        logic [6:0] exp;
    } vec_t;

    vec_t        vecs[12];
    logic [6:0]  exp_q[$];
    int          lat_src[$];
    int          lat_q[$];
    int          cnt_b;
    bit          auto_done;
    bit          stale_mode;
    string       cur_test;
    int          checks;
    int          errors;

    function automatic logic [6:0] pk(input logic r, input logic b, input logic f, input logic [3:0] i);
        return {r, b, f, i};
    endfunction

    function automatic logic [6:0] obs();
        return {bus.buzz_restart, bus.busy, bus.finished, bus.play_index};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got restart=%0b busy=%0b finished=%0b play_index=%0d, expected restart=%0b busy=%0b finished=%0b play_index=%0d",
                     name, $time, act[6], act[5], act[4], act[3:0], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0b, expected %0b", name, $time, act, exp);
        end
    endtask

    // One cycle: compare at the falling edge, then advance the buzzer-stage model.
    task automatic step();
        logic done;
        @(negedge clk);
        if (exp_q.size() > 0) check(cur_test, obs(), exp_q.pop_front());
        if (bus.buzz_restart) begin
            if (cnt_b > 0 && lat_q.size() > 0) void'(lat_q.pop_front());
            cnt_b = 0;
        end else begin
            cnt_b++;
        end
        done = 1'b0;
        if (auto_done && lat_q.size() > 0 && cnt_b >= lat_q[0]) done = 1'b1;
        if (stale_mode && cnt_b <= 1) done = 1'b1;
        bus.buzz_done = done;
    endtask

    task automatic run_q();
        while (exp_q.size() > 0) step();
    endtask

    // Expected trace of n plays: ARM cycles, play cycles, then a gap or the finish pulse.
    task automatic build(input int n, input bit loop_mode);
        for (int k = 1; k <= n; k++) begin
            logic [3:0] idx;
            logic [3:0] nxt;
            idx = 4'(k % 16);
            nxt = 4'((k + 1) % 16);
            for (int c = 0; c < ARM; c++) exp_q.push_back(pk(1'b1, 1'b1, 1'b0, idx));
            for (int c = 0; c < lat_src[k-1]; c++) exp_q.push_back(pk(1'b0, 1'b1, 1'b0, idx));
            if (!loop_mode && k == n) begin
                exp_q.push_back(pk(1'b1, 1'b0, 1'b1, idx));
                exp_q.push_back(pk(1'b1, 1'b0, 1'b0, idx));
                exp_q.push_back(pk(1'b1, 1'b0, 1'b0, idx));
            end else begin
                for (int c = 0; c < GAP; c++) exp_q.push_back(pk(1'b1, 1'b1, 1'b0, nxt));
            end
        end
    endtask

    task automatic start_run(input logic [3:0] rep);
        lat_q = lat_src;
        bus.repeat_cnt = rep;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.repeat_cnt = 4'($urandom_range(0, 15));
        run_q();
    endtask

    task automatic idle_expect(input int n, input logic [3:0] idx);
        for (int c = 0; c < n; c++) exp_q.push_back(pk(1'b1, 1'b0, 1'b0, idx));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got running, expected done");
        $fatal(1, "bench timeout");
    end

    initial begin
        checks = 0; errors = 0; cnt_b = 0;
        auto_done = 1'b1; stale_mode = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.repeat_cnt = 4'd0; bus.buzz_done = 1'b0;
        reset = 1'b1;

        vecs[0]  = '{1'b0, 1'b0, 4'd0, pk(1'b1, 1'b0, 1'b0, 4'd0)};
        vecs[1]  = '{1'b1, 1'b1, 4'd2, pk(1'b1, 1'b0, 1'b0, 4'd0)};
        vecs[2]  = '{1'b1, 1'b0, 4'd2, pk(1'b1, 1'b1, 1'b0, 4'd1)};
        vecs[3]  = '{1'b1, 1'b0, 4'd5, pk(1'b1, 1'b1, 1'b0, 4'd1)};
        vecs[4]  = '{1'b0, 1'b0, 4'd0, pk(1'b1, 1'b1, 1'b0, 4'd1)};
        vecs[5]  = '{1'b0, 1'b1, 4'd0, pk(1'b1, 1'b0, 1'b0, 4'd0)};
        vecs[6]  = '{1'b1, 1'b0, 4'd1, pk(1'b1, 1'b1, 1'b0, 4'd1)};
        vecs[7]  = '{1'b0, 1'b0, 4'd0, pk(1'b1, 1'b1, 1'b0, 4'd1)};
        vecs[8]  = '{1'b0, 1'b0, 4'd0, pk(1'b1, 1'b1, 1'b0, 4'd1)};
        vecs[9]  = '{1'b0, 1'b0, 4'd0, pk(1'b1, 1'b1, 1'b0, 4'd1)};
        vecs[10] = '{1'b0, 1'b0, 4'd0, pk(1'b0, 1'b1, 1'b0, 4'd1)};
        vecs[11] = '{1'b0, 1'b1, 4'd0, pk(1'b1, 1'b0, 1'b0, 4'd0)};

        @(negedge clk);
        check("reset_values", obs(), pk(1'b1, 1'b0, 1'b0, 4'd0));
`ifdef BUZZER_SEQ_TIMEOUT_EN
        check1("reset_timeout_err", bus.timeout_err, 1'b0);
`endif
        reset = 1'b0;

        cur_test = "vector";
        auto_done = 1'b0;
        for (int v = 0; v < 12; v++) begin
            bus.start = vecs[v].start;
            bus.stop = vecs[v].stop;
            bus.repeat_cnt = vecs[v].rep;
            exp_q.push_back(vecs[v].exp);
            step();
        end
        bus.start = 1'b0; bus.stop = 1'b0;
        auto_done = 1'b1;

        cur_test = "basic_repeat";
        lat_src = {50, 50};
        build(2, 1'b0);
        start_run(4'd2);

        cur_test = "random_repeat";
        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(1, 3));
            lat_src = {};
            for (int k = 0; k < n; k++) lat_src.push_back(int'($urandom_range(2, 25)));
            build(n, 1'b0);
            start_run(4'(n));
        end

        cur_test = "loop_mode";
        lat_src = {};
        for (int k = 0; k < 17; k++) lat_src.push_back(int'($urandom_range(2, 6)));
        build(17, 1'b1);
        repeat (GAP - 3) void'(exp_q.pop_back());
        start_run(4'd0);
        bus.stop = 1'b1;
        cur_test = "loop_stop";
        idle_expect(1, 4'd0);
        step();
        bus.stop = 1'b0;
        idle_expect(2, 4'd0);
        run_q();

        cur_test = "stop_mid_play";
        lat_src = {40, 40, 40};
        build(3, 1'b0);
        while (exp_q.size() > ARM + 10) void'(exp_q.pop_back());
        start_run(4'd3);
        bus.stop = 1'b1;
        idle_expect(1, 4'd0);
        step();
        bus.stop = 1'b0;
        idle_expect(3, 4'd0);
        run_q();

        cur_test = "start_stop_same_cycle";
        bus.start = 1'b1; bus.stop = 1'b1; bus.repeat_cnt = 4'd2;
        idle_expect(1, 4'd0);
        step();
        bus.start = 1'b0; bus.stop = 1'b0;
        idle_expect(4, 4'd0);
        run_q();

        cur_test = "stale_done";
        stale_mode = 1'b1;
        idle_expect(3, 4'd0);
        run_q();
        lat_src = {8};
        build(1, 1'b0);
        start_run(4'd1);
        stale_mode = 1'b0;

        cur_test = "reset_mid_gap";
        lat_src = {50, 50};
        build(2, 1'b0);
        while (exp_q.size() > ARM + 50 + 4) void'(exp_q.pop_back());
        start_run(4'd2);
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", obs(), pk(1'b1, 1'b0, 1'b0, 4'd0));
        @(negedge clk);
        reset = 1'b0;
        lat_q = {};
        cnt_b = 0;
        cur_test = "after_reset";
        idle_expect(2, 4'd0);
        run_q();
        build(2, 1'b0);
        start_run(4'd2);

`ifdef BUZZER_SEQ_TIMEOUT_EN
        cur_test = "timeout";
        auto_done = 1'b0;
        lat_src = {};
        for (int c = 0; c < ARM; c++) exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 4'd1));
        for (int c = 0; c < TO; c++) exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 4'd1));
        idle_expect(2, 4'd1);
        start_run(4'd1);
        check1("timeout_err_set", bus.timeout_err, 1'b1);
        step();
        check1("timeout_err_sticky", bus.timeout_err, 1'b1);
        bus.start = 1'b1; bus.repeat_cnt = 4'd1;
        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 4'd1));
        step();
        bus.start = 1'b0;
        check1("timeout_err_clear", bus.timeout_err, 1'b0);
        bus.stop = 1'b1;
        idle_expect(1, 4'd0);
        step();
        bus.stop = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
